// File: rtl/truth_table_sweeper_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_pkg
// Shared types and helpers for the truth-table sweeper:
//   state_t      - sweep controller state (IDLE, RUN)
//   MAX_N_IN     - widest supported DUT input count
//   num_vectors  - sweep length for a given input count
//   vec_of       - maps a sweep index to the applied vector (binary or Gray)
// ---------------------------------------------------------------------------
package truth_table_sweeper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MAX_N_IN = 6;

  function automatic int unsigned num_vectors(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic logic [MAX_N_IN-1:0] vec_of(input logic [MAX_N_IN-1:0] index,
                                                 input bit                  gray);
    return gray ? (index ^ (index >> 1)) : index;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_order_gen.sv
// ---------------------------------------------------------------------------
// sweep_order_gen
// Walks the sweep index through 0 .. 2**N_IN-1, holding each applied vector
// for SETTLE cycles.
//   clk, rst    - clock, synchronous active-high reset
//   i_start     - accepted start: restart at index 0 / vector 0
//   i_run       - sweep in progress
//   o_dut_in    - registered stimulus vector
//   o_sample    - high on the edge where the current vector is sampled
//   o_last      - current index is the final one of the sweep
// ---------------------------------------------------------------------------
module sweep_order_gen
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned GRAY   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_run,
  output logic [N_IN-1:0] o_dut_in,
  output logic            o_sample,
  output logic            o_last
);

  localparam int unsigned NV = num_vectors(N_IN);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [N_IN-1:0] r_idx;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_dut_in;
  logic [N_IN-1:0] w_idx_nxt;
  logic [N_IN-1:0] w_vec_nxt;

  assign w_idx_nxt = r_idx + N_IN'(1);
  assign w_vec_nxt = N_IN'(vec_of(MAX_N_IN'(w_idx_nxt), GRAY != 0));

  // Last index is compared explicitly; the index never wraps during a sweep.
  assign o_last   = (r_idx == N_IN'(NV - 1));
  assign o_sample = i_run && (r_cnt == CW'(SETTLE - 1));
  assign o_dut_in = r_dut_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_dut_in <= '0;
    end else if (i_start) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_dut_in <= '0;
    end else if (i_run) begin
      if (o_sample) begin
        if (!o_last) begin
          r_idx    <= w_idx_nxt;
          r_dut_in <= w_vec_nxt;
          r_cnt    <= '0;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustive-stimulus checker for a small combinational DUT with a 1-bit
// output: applies every input vector, captures the observed truth table and
// compares it against EXPECT.
//   clk, rst      - clock, synchronous active-high reset
//   start         - begin a sweep (ignored while busy)
//   dut_in        - registered stimulus to the DUT
//   dut_out       - DUT response
//   busy          - sweep in progress
//   done          - one-cycle completion pulse
//   pass          - observed table equals EXPECT (valid from done)
//   mismatch_cnt  - number of mismatching vectors
//   fail_valid    - at least one mismatch recorded
//   first_fail    - first mismatching vector in sweep order
//   cap_table     - observed table, bit k = response to dut_in==k
// ---------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned           N_IN   = 3,
  parameter int unsigned           SETTLE = 2,
  parameter int unsigned           GRAY   = 0,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 8'hE8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail,
  output logic [(1<<N_IN)-1:0] cap_table
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_run;
  logic w_sample;
  logic w_last;
  logic w_miss;
  logic w_finish;

  logic                 r_done;
  logic                 r_pass;
  logic [N_IN:0]        r_mis_cnt;
  logic                 r_fail_valid;
  logic [N_IN-1:0]      r_first_fail;
  logic [(1<<N_IN)-1:0] r_cap;

  assign w_accept = (r_state == IDLE) && start;
  assign w_run    = (r_state == RUN);
  assign w_miss   = w_sample && (dut_out != EXPECT[dut_in]);
  assign w_finish = w_sample && w_last;

  sweep_order_gen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE),
    .GRAY   (GRAY)
  ) u_order (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_run    (w_run),
    .o_dut_in (dut_in),
    .o_sample (w_sample),
    .o_last   (w_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start)    w_state_nxt = RUN;
      RUN:  if (w_finish) w_state_nxt = IDLE;
      default:            w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == RUN);
  end

  // Compare, capture and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_mis_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_cap        <= '0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_pass       <= 1'b0;
        r_mis_cnt    <= '0;
        r_fail_valid <= 1'b0;
        r_first_fail <= '0;
        r_cap        <= '0;
      end else if (w_sample) begin
        r_cap[dut_in] <= dut_out;
        if (w_miss) begin
          r_mis_cnt <= r_mis_cnt + (N_IN+1)'(1);
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_first_fail <= dut_in;
          end
        end
        // Final verdict must include the sample taken on this same edge.
        if (w_last) r_pass <= (r_mis_cnt == '0) && !w_miss;
      end
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign mismatch_cnt = r_mis_cnt;
  assign fail_valid   = r_fail_valid;
  assign first_fail   = r_first_fail;
  assign cap_table    = r_cap;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic fault_a;
  logic st_a, st_b, st_c;

  // Instance A: defaults, majority or a&b DUT
  logic [2:0] din_a;  logic dout_a;
  logic busy_a, done_a, pass_a, fv_a;
  logic [3:0] cnt_a;  logic [2:0] ff_a;  logic [7:0] cap_a;
  // Instance B: Gray order, a&b DUT
  logic [2:0] din_b;  logic dout_b;
  logic busy_b, done_b, pass_b, fv_b;
  logic [3:0] cnt_b;  logic [2:0] ff_b;  logic [7:0] cap_b;
  // Instance C: N_IN=2, SETTLE=1, XOR DUT
  logic [1:0] din_c;  logic dout_c;
  logic busy_c, done_c, pass_c, fv_c;
  logic [2:0] cnt_c;  logic [1:0] ff_c;  logic [3:0] cap_c;

  assign dout_a = fault_a ? (din_a[0] & din_a[1])
                          : ((din_a[0] & din_a[1]) | (din_a[0] & din_a[2]) | (din_a[1] & din_a[2]));
  assign dout_b = din_b[0] & din_b[1];
  assign dout_c = din_c[0] ^ din_c[1];

  truth_table_sweeper u_a (
    .clk(clk), .rst(rst), .start(st_a), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_cnt(cnt_a),
    .fail_valid(fv_a), .first_fail(ff_a), .cap_table(cap_a));

  truth_table_sweeper #(.GRAY(1)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(cnt_b),
    .fail_valid(fv_b), .first_fail(ff_b), .cap_table(cap_b));

  truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'h6)) u_c (
    .clk(clk), .rst(rst), .start(st_c), .dut_in(din_c), .dut_out(dout_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_cnt(cnt_c),
    .fail_valid(fv_c), .first_fail(ff_c), .cap_table(cap_c));

  typedef struct packed {
    logic       busy, done, pass, fv;
    logic [7:0] cnt, ff, cap, din;
  } res_t;

  typedef struct {
    int         inst;
    logic       fault;
    int         exp_lat;
    logic       exp_pass;
    logic [7:0] exp_cnt;
    logic       exp_fv;
    logic [7:0] exp_ff;
    logic [7:0] exp_cap;
    logic [7:0] exp_last;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] trace [0:63];
  logic       start_busy;
  logic [7:0] gorder [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t snap(input int inst);
    res_t r;
    case (inst)
      0: r = '{busy_a, done_a, pass_a, fv_a, 8'(cnt_a), 8'(ff_a), cap_a, 8'(din_a)};
      1: r = '{busy_b, done_b, pass_b, fv_b, 8'(cnt_b), 8'(ff_b), cap_b, 8'(din_b)};
      default: r = '{busy_c, done_c, pass_c, fv_c, 8'(cnt_c), 8'(ff_c), 8'(cap_c), 8'(din_c)};
    endcase
    return r;
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: st_a = v;
      1: st_b = v;
      default: st_c = v;
    endcase
  endtask

  // Pulses start for one edge; lat counts edges after the start edge up to done.
  task automatic run_sweep(input int inst, output int lat);
    res_t r;
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    lat = 0;
    r = snap(inst);
    trace[0] = r.din;
    start_busy = r.busy;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      r = snap(inst);
      if (r.done) break;
      if (lat < 64) trace[lat] = r.din;
    end
  endtask

  initial begin
    vec_t tbl [4];
    res_t r;
    int   lat;
    int   settle, nv, n, seen;
    int   d [3];
    int   nd;
    logic [7:0] expv;

    gorder = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4};
    // Majority vs a&b differs only at vectors 5 and 6.
    tbl[0] = '{0, 1'b0, 16, 1'b1, 8'd0, 1'b0, 8'd0, 8'hE8, 8'd7};
    tbl[1] = '{0, 1'b1, 16, 1'b0, 8'd2, 1'b1, 8'd5, 8'h88, 8'd7};
    tbl[2] = '{1, 1'b0, 16, 1'b0, 8'd2, 1'b1, 8'd6, 8'h88, 8'd4};
    tbl[3] = '{2, 1'b0,  4, 1'b1, 8'd0, 1'b0, 8'd0, 8'h06, 8'd3};

    rst = 1'b1; st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; fault_a = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_state_%0d", i), 64'(snap(i)), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      fault_a = tbl[t].fault;
      run_sweep(tbl[t].inst, lat);
      r = snap(tbl[t].inst);
      chk($sformatf("t%0d_busy_start", t), 64'(start_busy), 64'd1);
      chk($sformatf("t%0d_latency", t), 64'(lat), 64'(tbl[t].exp_lat));
      chk($sformatf("t%0d_busy_done", t), 64'(r.busy), 64'd0);
      chk($sformatf("t%0d_pass", t), 64'(r.pass), 64'(tbl[t].exp_pass));
      chk($sformatf("t%0d_mismatch_cnt", t), 64'(r.cnt), 64'(tbl[t].exp_cnt));
      chk($sformatf("t%0d_fail_valid", t), 64'(r.fv), 64'(tbl[t].exp_fv));
      chk($sformatf("t%0d_first_fail", t), 64'(r.ff), 64'(tbl[t].exp_ff));
      chk($sformatf("t%0d_cap_table", t), 64'(r.cap), 64'(tbl[t].exp_cap));
      chk($sformatf("t%0d_last_vec", t), 64'(r.din), 64'(tbl[t].exp_last));
      settle = (tbl[t].inst == 2) ? 1 : 2;
      nv     = (tbl[t].inst == 2) ? 4 : 8;
      for (int j = 0; j < nv; j++) begin
        expv = (tbl[t].inst == 1) ? gorder[j] : 8'(j);
        for (int s = 0; s < settle; s++)
          chk($sformatf("t%0d_order_%0d_%0d", t, j, s), 64'(trace[j*settle+s]), 64'(expv));
        if (tbl[t].inst == 1 && j > 0)
          chk($sformatf("t%0d_gray_step_%0d", t, j),
              64'($countones(trace[j*settle] ^ trace[(j-1)*settle])), 64'd1);
      end
      @(negedge clk);
      r = snap(tbl[t].inst);
      chk($sformatf("t%0d_done_one_cycle", t), 64'(r.done), 64'd0);
      chk($sformatf("t%0d_pass_held", t), 64'(r.pass), 64'(tbl[t].exp_pass));
      chk($sformatf("t%0d_cap_held", t), 64'(r.cap), 64'(tbl[t].exp_cap));
    end

    // Reset in the middle of a sweep, while dut_in == 4.
    fault_a = 1'b1;
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    n = 0;
    while (din_a != 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_vec4", 64'(din_a), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", 64'(snap(0)), 64'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    fault_a = 1'b0;
    run_sweep(0, lat);
    chk("rst_resweep_latency", 64'(lat), 64'd16);
    chk("rst_resweep_pass", 64'(pass_a), 64'd1);
    chk("rst_resweep_cap", 64'(cap_a), 64'hE8);
    chk("rst_resweep_cnt", 64'(cnt_a), 64'd0);
    @(negedge clk);

    // start held high: restarts only in the done cycle, done pulses 17 edges apart.
    st_a = 1'b1;
    nd = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_a && nd < 3) begin
        d[nd] = k;
        nd++;
      end
      if (k == 10) chk("held_busy_mid", 64'(busy_a), 64'd1);
      if (k == 10) chk("held_no_restart", 64'(din_a), 64'd4);
    end
    st_a = 1'b0;
    chk("held_done_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("held_first_done", 64'(d[0]), 64'd17);
      chk("held_gap_1", 64'(d[1] - d[0]), 64'd17);
      chk("held_gap_2", 64'(d[2] - d[1]), 64'd17);
    end
    repeat (20) @(negedge clk);
    chk("held_final_pass", 64'(pass_a), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
